// File: rtl/mem_access.sv
// Memory-access pipeline stage: turns EX/MEM load/store requests into one data-bus
// transaction with lane steering, a timeout, and a registered writeback to MEM/WB.
module mem_access #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int RADDR_WIDTH = 5,
   parameter int TIMEOUT     = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
   input  logic                   reg_we_i,
   input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
   input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
   input  logic [DATA_WIDTH-1:0]  mem_data_i,
   input  logic                   mem_we_i,
   input  logic [3:0]             mem_op_i,
   output logic                   dbus_req_o,
   output logic                   dbus_we_o,
   output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
   output logic [3:0]             dbus_be_o,
   output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
   input  logic                   dbus_ack_i,
   input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic                   reg_we_o,
   output logic [DATA_WIDTH-1:0]  reg_wdata_o,
   output logic                   stall_o,
   output logic                   misalign_o,
   output logic                   bus_err_o
);

   // state  | meaning
   // IDLE   | pass-through writeback, accept a new load/store
   // BUSY   | bus request outstanding, waiting for ack or timeout
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [0:0]             state;
   logic [3:0]             op_q;
   logic [1:0]             off_q;
   logic [RADDR_WIDTH-1:0] waddr_q;
   logic                   we_q;
   logic [CW-1:0]          cnt;

   logic                   is_load, is_store, sz_byte, sz_half, sz_word;
   logic                   mis_op, accept, tmo;
   logic [3:0]             be_next;
   logic [DATA_WIDTH-1:0]  wdata_next;
   logic [7:0]             lane_b;
   logic [15:0]            lane_h;
   logic [DATA_WIDTH-1:0]  load_data;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      sz_byte  = 1'b0;
      sz_half  = 1'b0;
      sz_word  = 1'b0;
      case (mem_op_i)
         OP_LB, OP_LBU: begin is_load = 1'b1;      sz_byte = 1'b1; end
         OP_LH, OP_LHU: begin is_load = 1'b1;      sz_half = 1'b1; end
         OP_LW:         begin is_load = 1'b1;      sz_word = 1'b1; end
         OP_SB:         begin is_store = mem_we_i; sz_byte = 1'b1; end
         OP_SH:         begin is_store = mem_we_i; sz_half = 1'b1; end
         OP_SW:         begin is_store = mem_we_i; sz_word = 1'b1; end
         default:       ;
      endcase
      mis_op = (is_load | is_store) &
               ((sz_half & mem_addr_i[0]) | (sz_word & (mem_addr_i[1:0] != 2'b00)));
      accept = (state == S_IDLE) & (is_load | is_store) & ~mis_op;

      be_next = 4'b1111;
      if (sz_byte)      be_next = 4'b0001 << mem_addr_i[1:0];
      else if (sz_half) be_next = 4'b0011 << {mem_addr_i[1], 1'b0};

      wdata_next = '0;
      if (is_store) begin
         if (sz_byte)      wdata_next = {4{mem_data_i[7:0]}};
         else if (sz_half) wdata_next = {2{mem_data_i[15:0]}};
         else              wdata_next = mem_data_i;
      end
   end

   // Lane selection uses the byte offset latched at accept, not the live address.
   always_comb begin
      case (off_q)
         2'd0:    lane_b = dbus_rdata_i[7:0];
         2'd1:    lane_b = dbus_rdata_i[15:8];
         2'd2:    lane_b = dbus_rdata_i[23:16];
         default: lane_b = dbus_rdata_i[31:24];
      endcase
      lane_h = off_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
      case (op_q)
         OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  load_data = {24'd0, lane_b};
         OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  load_data = {16'd0, lane_h};
         default: load_data = dbus_rdata_i;
      endcase
   end

   assign tmo = (cnt == CW'(TIMEOUT - 1));

   // Gated by rst_i so the hold request drops the moment reset asserts.
   assign stall_o = ~rst_i & (accept | ((state == S_BUSY) & ~dbus_ack_i & ~tmo));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         op_q         <= '0;
         off_q        <= '0;
         waddr_q      <= '0;
         we_q         <= 1'b0;
         cnt          <= '0;
         dbus_req_o   <= 1'b0;
         dbus_we_o    <= 1'b0;
         dbus_addr_o  <= '0;
         dbus_be_o    <= '0;
         dbus_wdata_o <= '0;
         reg_waddr_o  <= '0;
         reg_we_o     <= 1'b0;
         reg_wdata_o  <= '0;
         misalign_o   <= 1'b0;
         bus_err_o    <= 1'b0;
      end else begin
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state        <= S_BUSY;
                  op_q         <= mem_op_i;
                  off_q        <= mem_addr_i[1:0];
                  waddr_q      <= reg_waddr_i;
                  we_q         <= reg_we_i & is_load;
                  cnt          <= '0;
                  dbus_req_o   <= 1'b1;
                  dbus_we_o    <= is_store;
                  dbus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  dbus_be_o    <= be_next;
                  dbus_wdata_o <= wdata_next;
                  reg_we_o     <= 1'b0;
               end else if (mis_op) begin
                  reg_waddr_o <= reg_waddr_i;
                  reg_we_o    <= 1'b0;
                  misalign_o  <= 1'b1;
               end else begin
                  reg_waddr_o <= reg_waddr_i;
                  reg_we_o    <= reg_we_i;
                  reg_wdata_o <= reg_wdata_i;
               end
            end
            S_BUSY: begin
               if (dbus_ack_i || tmo) begin
                  state        <= S_IDLE;
                  dbus_req_o   <= 1'b0;
                  dbus_we_o    <= 1'b0;
                  dbus_addr_o  <= '0;
                  dbus_be_o    <= '0;
                  dbus_wdata_o <= '0;
                  if (dbus_ack_i) begin
                     reg_waddr_o <= waddr_q;
                     reg_we_o    <= we_q;
                     reg_wdata_o <= load_data;
                  end else begin
                     reg_we_o  <= 1'b0;
                     bus_err_o <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, lane steering, misalignment,
// timeout, ack/timeout tie-break and reset abandoning a transaction.
module tb_mem_access;

   localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4;
   localparam logic [3:0] LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  reg_waddr_i;
   logic        reg_we_i;
   logic [31:0] reg_wdata_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic        mem_we_i;
   logic [3:0]  mem_op_i;
   logic        dbus_req_o, dbus_we_o, dbus_ack_i;
   logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
   logic [3:0]  dbus_be_o;
   logic [4:0]  reg_waddr_o;
   logic        reg_we_o;
   logic [31:0] reg_wdata_o;
   logic        stall_o, misalign_o, bus_err_o;

   int checks = 0;
   int errors = 0;

   mem_access dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
      .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_we_i(mem_we_i),
      .mem_op_i(mem_op_i),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i),
      .dbus_rdata_i(dbus_rdata_i),
      .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
      .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input logic [3:0] op, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] wa, input logic rwe,
                          input logic [31:0] wd);
      mem_op_i    = op;
      mem_we_i    = we;
      mem_addr_i  = addr;
      mem_data_i  = data;
      reg_waddr_i = wa;
      reg_we_i    = rwe;
      reg_wdata_i = wd;
   endtask

   task automatic idle_in();
      set_req(NOP, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
   endtask

   task automatic test_reset();
      logic [111:0] all_out;
      rst_i = 1'b1;
      dbus_ack_i = 1'b1;
      dbus_rdata_i = 32'hFFFF_FFFF;
      set_req(LW, 1'b0, 32'h40, 32'h0, 5'd1, 1'b1, 32'h0);
      #2;
      all_out = {dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, reg_waddr_o,
                 reg_we_o, stall_o, misalign_o, bus_err_o, 32'h0};
      checks++; if (all_out !== 112'h0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", all_out); end
      step();
      step();
      checks++; if (reg_wdata_o !== 32'h0 || dbus_req_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL reset_held: wdata %h req %b stall %b exp 0", reg_wdata_o, dbus_req_o, stall_o); end
      rst_i = 1'b0;
      dbus_ack_i = 1'b0;
      idle_in();
      step();
   endtask

   task automatic test_nop();
      set_req(NOP, 1'b0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL nop_stall: got %b exp 0", stall_o); end
      step();
      checks++; if ({reg_waddr_o, reg_we_o, reg_wdata_o} !== {5'd5, 1'b1, 32'h1234}) begin errors++; $display("FAIL nop_wb: got %h/%b/%h exp 05/1/00001234", reg_waddr_o, reg_we_o, reg_wdata_o); end
      checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL nop_req: got %b exp 0", dbus_req_o); end
      set_req(SW, 1'b0, 32'h10, 32'h5555, 5'd3, 1'b1, 32'hBEEF);
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL sw_no_we_stall: got %b exp 0", stall_o); end
      step();
      checks++; if ({reg_waddr_o, reg_wdata_o, dbus_req_o} !== {5'd3, 32'hBEEF, 1'b0}) begin errors++; $display("FAIL sw_no_we_nop: got %h/%h/%b exp 03/0000beef/0", reg_waddr_o, reg_wdata_o, dbus_req_o); end
      idle_in();
   endtask

   task automatic test_lb();
      int n = 0;
      logic stable = 1'b1;
      set_req(LB, 1'b0, 32'h103, 32'h0, 5'd7, 1'b1, 32'h0);
      #1;
      if (stall_o) n++;
      step();
      set_req(SW, 1'b1, 32'h8, 32'hFFFF, 5'd1, 1'b1, 32'h1);
      checks++; if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o} !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin errors++; $display("FAIL lb_bus: got req %b we %b addr %h be %b exp 1 0 00000100 1000", dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o); end
      for (int k = 0; k < 3; k++) begin
         #1;
         if (stall_o) n++;
         if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o} !== {1'b1, 1'b0, 32'h100, 4'b1000}) stable = 1'b0;
         step();
      end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL lb_bus_stable: got %b exp 1", stable); end
      dbus_ack_i = 1'b1;
      dbus_rdata_i = 32'h80FF_FF00;
      #1;
      if (stall_o) n++;
      step();
      dbus_ack_i = 1'b0;
      idle_in();
      checks++; if (n !== 4) begin errors++; $display("FAIL lb_stall_cycles: got %0d exp 4", n); end
      checks++; if ({reg_waddr_o, reg_we_o, reg_wdata_o} !== {5'd7, 1'b1, 32'hFFFF_FF80}) begin errors++; $display("FAIL lb_wb: got %h/%b/%h exp 07/1/ffffff80", reg_waddr_o, reg_we_o, reg_wdata_o); end
      checks++; if (dbus_req_o !== 1'b0 || dbus_be_o !== 4'b0) begin errors++; $display("FAIL lb_bus_idle: got req %b be %b exp 0 0000", dbus_req_o, dbus_be_o); end
   endtask

   task automatic test_sh();
      set_req(SH, 1'b1, 32'h202, 32'h0000_ABCD, 5'd2, 1'b1, 32'h0);
      step();
      idle_in();
      checks++; if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o} !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD}) begin errors++; $display("FAIL sh_bus: got req %b we %b addr %h be %b wdata %h", dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o); end
      dbus_ack_i = 1'b1;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL sh_ack_stall: got %b exp 0", stall_o); end
      step();
      dbus_ack_i = 1'b0;
      checks++; if (reg_we_o !== 1'b0 || dbus_req_o !== 1'b0) begin errors++; $display("FAIL sh_done: got we %b req %b exp 0 0", reg_we_o, dbus_req_o); end
   endtask

   task automatic test_misalign();
      set_req(LW, 1'b0, 32'h101, 32'h0, 5'd4, 1'b1, 32'h0);
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b exp 0", stall_o); end
      step();
      idle_in();
      checks++; if ({misalign_o, reg_we_o, dbus_req_o, bus_err_o} !== 4'b1000) begin errors++; $display("FAIL mis_pulse: got mis/we/req/err %b exp 1000", {misalign_o, reg_we_o, dbus_req_o, bus_err_o}); end
      step();
      checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_single: got %b exp 0", misalign_o); end
      set_req(SH, 1'b1, 32'h203, 32'h1, 5'd4, 1'b0, 32'h0);
      step();
      idle_in();
      checks++; if ({misalign_o, dbus_req_o} !== 2'b10) begin errors++; $display("FAIL mis_sh: got mis/req %b exp 10", {misalign_o, dbus_req_o}); end
      set_req(LHU, 1'b0, 32'h2, 32'h0, 5'd6, 1'b1, 32'h0);
      step();
      idle_in();
      checks++; if ({dbus_req_o, dbus_addr_o, dbus_be_o} !== {1'b1, 32'h0, 4'b1100}) begin errors++; $display("FAIL lhu_bus: got req %b addr %h be %b exp 1 00000000 1100", dbus_req_o, dbus_addr_o, dbus_be_o); end
      dbus_ack_i = 1'b1;
      dbus_rdata_i = 32'h8001_0000;
      step();
      dbus_ack_i = 1'b0;
      checks++; if ({reg_waddr_o, reg_we_o, reg_wdata_o} !== {5'd6, 1'b1, 32'h0000_8001}) begin errors++; $display("FAIL lhu_wb: got %h/%b/%h exp 06/1/00008001", reg_waddr_o, reg_we_o, reg_wdata_o); end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_wb;
   } vec_t;

   task automatic test_lanes();
      vec_t v[7];
      v[0] = '{LBU, 1'b0, 32'h101, 32'h0, 32'h0000_9A00, 4'b0010, 32'h0, 32'h0000_009A};
      v[1] = '{LB,  1'b0, 32'h100, 32'h0, 32'h0000_007F, 4'b0001, 32'h0, 32'h0000_007F};
      v[2] = '{LH,  1'b0, 32'h106, 32'h0, 32'hF234_0000, 4'b1100, 32'h0, 32'hFFFF_F234};
      v[3] = '{LH,  1'b0, 32'h104, 32'h0, 32'h0000_7FFF, 4'b0011, 32'h0, 32'h0000_7FFF};
      v[4] = '{LW,  1'b0, 32'h108, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF};
      v[5] = '{SB,  1'b1, 32'h005, 32'h1234_5678, 32'h0, 4'b0010, 32'h7878_7878, 32'h0};
      v[6] = '{SW,  1'b1, 32'h00C, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0};
      for (int i = 0; i < 7; i++) begin
         set_req(v[i].op, v[i].we, v[i].addr, v[i].data, 5'd8, 1'b1, 32'h0);
         step();
         idle_in();
         checks++; if ({dbus_be_o, dbus_wdata_o, dbus_we_o} !== {v[i].be, v[i].exp_wdata, v[i].we}) begin errors++; $display("FAIL lane_bus[%0d]: got be %b wdata %h we %b exp %b %h %b", i, dbus_be_o, dbus_wdata_o, dbus_we_o, v[i].be, v[i].exp_wdata, v[i].we); end
         dbus_ack_i = 1'b1;
         dbus_rdata_i = v[i].rdata;
         step();
         dbus_ack_i = 1'b0;
         if (!v[i].we) begin
            checks++; if ({reg_we_o, reg_wdata_o} !== {1'b1, v[i].exp_wb}) begin errors++; $display("FAIL lane_wb[%0d]: got we %b data %h exp 1 %h", i, reg_we_o, reg_wdata_o, v[i].exp_wb); end
         end else begin
            checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL lane_store_we[%0d]: got %b exp 0", i, reg_we_o); end
         end
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      logic ok = 1'b1;
      set_req(LW, 1'b0, 32'h40, 32'h0, 5'd1, 1'b1, 32'h0);
      step();
      idle_in();
      for (int k = 1; k <= 16; k++) begin
         if (dbus_req_o) n++;
         if (stall_o !== (k < 16)) ok = 1'b0;
         if (bus_err_o) ok = 1'b0;
         step();
      end
      checks++; if (n !== 16) begin errors++; $display("FAIL tmo_req_cycles: got %0d exp 16", n); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_stall_profile: got %b exp 1", ok); end
      checks++; if ({bus_err_o, dbus_req_o, reg_we_o, stall_o, misalign_o} !== 5'b10000) begin errors++; $display("FAIL tmo_err: got err/req/we/stall/mis %b exp 10000", {bus_err_o, dbus_req_o, reg_we_o, stall_o, misalign_o}); end
      dbus_ack_i = 1'b1;
      dbus_rdata_i = 32'h1111_1111;
      step();
      dbus_ack_i = 1'b0;
      checks++; if ({bus_err_o, dbus_req_o, reg_we_o, reg_waddr_o} !== {3'b000, 5'd0}) begin errors++; $display("FAIL tmo_late_ack: got err/req/we %b waddr %h exp 000 00", {bus_err_o, dbus_req_o, reg_we_o}, reg_waddr_o); end
   endtask

   task automatic test_ack_at_timeout();
      set_req(LW, 1'b0, 32'h44, 32'h0, 5'd2, 1'b1, 32'h0);
      step();
      idle_in();
      repeat (15) step();
      dbus_ack_i = 1'b1;
      dbus_rdata_i = 32'h1357_9BDF;
      #1;
      checks++; if (stall_o !== 1'b0 || dbus_req_o !== 1'b1) begin errors++; $display("FAIL tie_last_cycle: got stall %b req %b exp 0 1", stall_o, dbus_req_o); end
      step();
      dbus_ack_i = 1'b0;
      checks++; if ({bus_err_o, reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b0, 1'b1, 5'd2, 32'h1357_9BDF}) begin errors++; $display("FAIL tie_ack_wins: got err %b we %b waddr %h data %h", bus_err_o, reg_we_o, reg_waddr_o, reg_wdata_o); end
   endtask

   task automatic test_reset_mid_busy();
      set_req(LW, 1'b0, 32'h80, 32'h0, 5'd3, 1'b1, 32'h0);
      step();
      idle_in();
      step();
      #1;
      rst_i = 1'b1;
      #1;
      checks++; if ({dbus_req_o, stall_o, reg_we_o} !== 3'b000) begin errors++; $display("FAIL rst_mid_busy: got req/stall/we %b exp 000", {dbus_req_o, stall_o, reg_we_o}); end
      dbus_ack_i = 1'b1;
      dbus_rdata_i = 32'hAAAA_5555;
      step();
      rst_i = 1'b0;
      step();
      dbus_ack_i = 1'b0;
      checks++; if ({reg_we_o, reg_waddr_o, bus_err_o, dbus_req_o} !== {1'b0, 5'd0, 2'b00}) begin errors++; $display("FAIL rst_no_wb: got we %b waddr %h err %b req %b exp 0 00 0 0", reg_we_o, reg_waddr_o, bus_err_o, dbus_req_o); end
      set_req(NOP, 1'b0, 32'h0, 32'h0, 5'd9, 1'b1, 32'h55);
      step();
      idle_in();
      checks++; if ({reg_waddr_o, reg_we_o, reg_wdata_o} !== {5'd9, 1'b1, 32'h55}) begin errors++; $display("FAIL rst_then_nop: got %h/%b/%h exp 09/1/00000055", reg_waddr_o, reg_we_o, reg_wdata_o); end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_lb();
      test_sh();
      test_misalign();
      test_lanes();
      test_timeout();
      test_ack_at_timeout();
      test_reset_mid_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, data-bus address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 Parameter RADDR_WIDTH, default 5, register-file address width.
REQ-004 Parameter TIMEOUT, default 16, maximum number of cycles the block waits for dbus_ack_i.
REQ-005 Clock and reset SHALL be one clock and an asynchronous, active-high reset: clk_i (1, in) and rst_i (1, in).
REQ-006 Ports: reg_waddr_i (in, RADDR_WIDTH), reg_we_i (in, 1), reg_wdata_i (in, 32): register writeback from the EX/MEM register.
REQ-007 Ports: mem_addr_i (in, ADDR_WIDTH), mem_data_i (in, 32), mem_we_i (in, 1), mem_op_i (in, 4): memory request from the EX/MEM register.
REQ-008 Ports: dbus_req_o (out, 1), dbus_we_o (out, 1), dbus_addr_o (out, ADDR_WIDTH), dbus_be_o (out, 4), dbus_wdata_o (out, 32), dbus_ack_i (in, 1), dbus_rdata_i (in, 32).
REQ-009 Ports: reg_waddr_o (out, RADDR_WIDTH), reg_we_o (out, 1), reg_wdata_o (out, 32): registered writeback to MEM/WB.
REQ-010 Ports: stall_o (out, 1, combinational hold request to upstream), misalign_o (out, 1), bus_err_o (out, 1).

Function
REQ-011 mem_op_i encoding SHALL be: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9-15 SHALL be treated as NOP.
REQ-012 A store SHALL be performed only when mem_we_i=1; a store code with mem_we_i=0 SHALL be treated as NOP.
REQ-013 FSM states SHALL be IDLE and BUSY.
REQ-014 In IDLE with NOP, the block SHALL register reg_*_i to reg_*_o on the next edge, with stall_o=0, for a latency of 1 cycle.
REQ-015 Misalignment: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0.
REQ-016 In IDLE with a misaligned op, there SHALL be no bus access and stall_o=0; next edge: reg_we_o=0, misalign_o=1 for one cycle.
REQ-017 In IDLE with an aligned op: stall_o=1 combinationally; next edge: latch op, byte offset, waddr and we; state→BUSY.
REQ-018 The block SHALL drive dbus_req_o=1 in every BUSY cycle.
REQ-019 dbus_addr_o SHALL be {addr[ADDR_WIDTH-1:2],2'b00}, and dbus_we_o SHALL be 1 only for stores.
REQ-020 dbus_be_o: byte ops 4'b0001<<addr[1:0]; half ops 4'b0011<<{addr[1],1'b0}; word ops 4'b1111.
REQ-021 dbus_wdata_o: SB {4{data[7:0]}}; SH {2{data[15:0]}}; SW data.
REQ-022 dbus_*_o SHALL be held stable throughout BUSY, and SHALL be 0 in IDLE.
REQ-023 In BUSY with dbus_ack_i=0, stall_o SHALL be 1.
REQ-024 In BUSY with dbus_ack_i=1, stall_o SHALL be 0; next edge: state→IDLE and register the writeback.
REQ-025 Inputs SHALL be ignored during BUSY.
REQ-026 Load data SHALL be extracted from the selected lane: LB/LH sign-extend, LBU/LHU zero-extend, LW full word; on an ack cycle, reg_wdata_o SHALL take this value.
REQ-027 On store completion, reg_we_o SHALL be 0.
REQ-028 Timeout: a counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-029 On the TIMEOUT-th cycle of BUSY without ack: stall_o=0; next edge: IDLE, reg_we_o=0, bus_err_o=1 for one cycle.
REQ-030 Ack and timeout SHALL NOT coincide as distinct events: ack in the final BUSY cycle SHALL win, with no bus_err_o.
REQ-031 dbus_ack_i in IDLE SHALL be ignored.
REQ-032 misalign_o and bus_err_o SHALL be single-cycle pulses and never asserted together.
REQ-033 The minimum latency for a load or store SHALL be 2 cycles: accept at T, req at T+1, ack at T+1, writeback valid at T+2.

Reset
REQ-034 rst_i=1 SHALL asynchronously force IDLE, zero the counter, and zero every output, including dbus_req_o and stall_o.
REQ-035 Reset mid-BUSY SHALL abandon the transaction immediately, with no writeback and no error pulse.
REQ-036 An ack arriving after a mid-BUSY reset SHALL be ignored.

Verification
REQ-037 Directed scenario: NOP, reg_waddr_i=5, reg_we_i=1, reg_wdata_i=0x1234 -> next cycle reg_*_o identical, stall_o=0, no dbus_req_o.
REQ-038 Directed scenario: LB addr 0x103, bus rdata 0x80FF_FF00, ack after 3 cycles -> be=1000, addr 0x100, stall_o=1 for 4 cycles, reg_wdata_o=0xFFFF_FF80.
REQ-039 Directed scenario: SH addr 0x202, data 0xABCD -> dbus_we_o=1, be=1100, wdata 0xABCD_ABCD, reg_we_o=0 after ack.
REQ-040 Directed scenario: LW addr 0x101 -> no req, misalign_o pulse, reg_we_o=0, stall_o=0; LHU addr 0x2 with rdata 0x8001_0000 -> reg_wdata_o 0x0000_8001.
REQ-041 Directed scenario: LW with no ack, TIMEOUT=16 -> req for 16 cycles, bus_err_o one pulse, stall_o released; a late ack is ignored.
REQ-042 Directed scenario: rst_i asserted in 2nd BUSY cycle -> dbus_req_o=0 in the same cycle, no writeback; after release, the next NOP passes.
